// File: rtl/serial_add_ctrl_if.sv
// Handshake and full-adder-cell signal bundle for serial_add_ctrl.
// slave is the controller's view; master is the requester/consumer/cell side.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;

    modport slave (
        input  in_valid, a, b, carry_in, out_ready, fa_sum, fa_cout,
        output in_ready, out_valid, sum, carry_out, overflow, busy,
               fa_a, fa_b, fa_cin
    );

    modport master (
        output in_valid, a, b, carry_in, out_ready, fa_sum, fa_cout,
        input  in_ready, out_valid, sum, carry_out, overflow, busy,
               fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: feeds one bit per clock (LSB first)
// to an external 1-bit full adder cell and collects sum/carry into a result.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic             w_fa_a;
    logic             w_fa_b;
    logic             w_fa_cin;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_shifted;

    assign w_sum_shifted = {bus.fa_sum, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_fa_a      = 1'b0;
        w_fa_b      = 1'b0;
        w_fa_cin    = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_busy   = 1'b1;
                w_step   = 1'b1;
                w_fa_a   = r_a_sh[0];
                w_fa_b   = r_b_sh[0];
                w_fa_cin = r_carry;
                if (r_cnt == LAST) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand shifters and partial sum advance only while the cell is in use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_sum_sh <= '0;
            r_carry  <= bus.carry_in;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_shifted;
            r_carry  <= bus.fa_cout;
            if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Result registers hold their value through DONE and the following IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_sum_shifted;
            r_cout <= bus.fa_cout;
            r_ovf  <= r_carry ^ bus.fa_cout;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.fa_a      = w_fa_a;
    assign bus.fa_b      = w_fa_b;
    assign bus.fa_cin    = w_fa_cin;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_cout;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural full adder cell,
// a vector table, directed multi-cycle sequences and randomized operations.
module tb_serial_add_ctrl;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External 1-bit full adder cell
    assign bus.fa_sum  = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
    assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_co;
        logic       exp_ov;
        logic [7:0] exp_cin_tr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer addition; carry into bit i from the low i bits.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output logic [7:0] s, output logic co, output logic ov,
                         output logic [7:0] cin_tr);
        int unsigned t;
        int unsigned m;
        int unsigned v;
        t  = int'(a) + int'(b) + int'(cin);
        s  = t[7:0];
        co = t[8];
        ov = (a[7] == b[7]) && (s[7] != a[7]);
        for (int i = 0; i < 8; i++) begin
            m = (32'd1 << i) - 32'd1;
            v = (int'(a) & m) + (int'(b) & m) + int'(cin);
            cin_tr[i] = v[i];
        end
    endtask

    // Called just after a negedge; operands are taken at the next posedge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        bus.in_valid = 1'b1;
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int nrun, output logic [7:0] ta,
                             output logic [7:0] tb, output logic [7:0] tc);
        bit ok;
        ok   = 1'b0;
        nrun = 0;
        ta   = '0;
        tb   = '0;
        tc   = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            if (nrun < 8) begin
                ta[nrun] = bus.fa_a;
                tb[nrun] = bus.fa_b;
                tc[nrun] = bus.fa_cin;
            end
            nrun++;
        end
        if (!ok) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic verify(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic eco, input logic eov,
                          input logic [7:0] ecin, input int nrun, input logic [7:0] ta,
                          input logic [7:0] tb, input logic [7:0] tc);
        check({tag, "_latency"}, 32'(nrun), 32'd8);
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_carry_out"}, 32'(bus.carry_out), 32'(eco));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(eov));
        check({tag, "_fa_a_seq"}, 32'(ta), 32'(a));
        check({tag, "_fa_b_seq"}, 32'(tb), 32'(b));
        check({tag, "_fa_cin_seq"}, 32'(tc), 32'(ecin));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nrun;
        logic [7:0] ta, tb, tc;
        logic [7:0] ms, mcin;
        logic       mco, mov;
        logic [7:0] ra, rb;
        logic       rc;
        logic [7:0] held_sum;
        logic       held_co, held_ov;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFE};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8'hFE};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFF};
        vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8'h02};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_carry_out", 32'(bus.carry_out), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_fa", 32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(nrun, ta, tb, tc);
            verify($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_sum,
                   vecs[i].exp_co, vecs[i].exp_ov, vecs[i].exp_cin_tr, nrun, ta, tb, tc);
            release_result();
        end

        // Backpressure: result held while new requests are refused
        start_op(8'h3C, 8'h0F, 1'b0);
        wait_done(nrun, ta, tb, tc);
        model(8'h3C, 8'h0F, 1'b0, ms, mco, mov, mcin);
        verify("bp", 8'h3C, 8'h0F, ms, mco, mov, mcin, nrun, ta, tb, tc);
        held_sum = ms;
        held_co  = mco;
        held_ov  = mov;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sum_stable", 32'({bus.sum, bus.carry_out, bus.overflow}),
                  32'({held_sum, held_co, held_ov}));
        end
        bus.a         = 8'h33;
        bus.b         = 8'h11;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_result_kept_idle", 32'(bus.sum), 32'(held_sum));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_done(nrun, ta, tb, tc);
        model(8'h33, 8'h11, 1'b0, ms, mco, mov, mcin);
        verify("after_bp", 8'h33, 8'h11, ms, mco, mov, mcin, nrun, ta, tb, tc);
        release_result();

        // Reset during the third RUN cycle
        start_op(8'h55, 8'h0F, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_fa", 32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        start_op(8'h10, 8'h20, 1'b0);
        wait_done(nrun, ta, tb, tc);
        verify("post_rst", 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 8'h00, nrun, ta, tb, tc);
        release_result();

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, ms, mco, mov, mcin);
            start_op(ra, rb, rc);
            wait_done(nrun, ta, tb, tc);
            verify($sformatf("rnd%0d", i), ra, rb, ms, mco, mov, mcin, nrun, ta, tb, tc);
            release_result();
        end

        // Back-to-back with in_valid and out_ready held high
        begin
            logic [7:0] opa[3];
            logic [7:0] rsum[3];
            logic       rco[3];
            logic       rov[3];
            int         tres[3];
            int         iss;
            int         got;
            opa = '{8'h01, 8'h02, 8'h80};
            iss = 0;
            got = 0;
            bus.out_ready = 1'b1;
            for (int c = 0; c < 100 && got < 3; c++) begin
                if (bus.out_valid) begin
                    rsum[got] = bus.sum;
                    rco[got]  = bus.carry_out;
                    rov[got]  = bus.overflow;
                    tres[got] = c;
                    got++;
                end
                if (got < 3) begin
                    if (bus.in_ready && iss < 3) begin
                        bus.a        = opa[iss];
                        bus.b        = opa[iss];
                        bus.carry_in = 1'b0;
                        bus.in_valid = 1'b1;
                        iss++;
                    end
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b0;
            check("b2b_count", 32'(got), 32'd3);
            if (got == 3) begin
                check("b2b_sum0", 32'(rsum[0]), 32'h02);
                check("b2b_sum1", 32'(rsum[1]), 32'h04);
                check("b2b_sum2", 32'(rsum[2]), 32'h00);
                check("b2b_flags0", 32'({rco[0], rov[0]}), 32'd0);
                check("b2b_flags2", 32'({rco[2], rov[2]}), 32'b11);
                check("b2b_interval1", 32'(tres[1] - tres[0]), 32'(W + 2));
                check("b2b_interval2", 32'(tres[2] - tres[1]), 32'(W + 2));
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            @(negedge clk);
            check("b2b_idle_after", 32'({bus.busy, bus.in_ready}), 32'b01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
